// File: rtl/motor_speed_decoder.sv
// Four-channel x4 quadrature decoder. Each channel keeps a saturating
// signed edge count over a fixed window. At the end of a window all four
// counts are snapshotted and then emitted as four back-to-back strobes.

// One channel: input synchronizer, x4 step decode, saturating accumulator,
// snapshot shadow and sticky illegal-transition flag.
module motor_speed_decoder_lane #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_i,
  input  logic                  b_i,
  input  logic                  dec_en_i,
  input  logic                  snap_i,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] shadow_o
);
  // Saturation bounds in one extra bit so the sum cannot wrap before clamping.
  // The negative bound is -(2^(W-1)-1), so the most-negative code never appears.
  localparam logic signed [DATA_WIDTH:0] SAT_P   = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] SAT_N   = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [DATA_WIDTH:0] STEP_UP = {{DATA_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [DATA_WIDTH:0] STEP_DN = {(DATA_WIDTH+1){1'b1}};

  logic [1:0]            sa_q, sb_q;   // 2-flop synchronizers, [1] is the output
  logic [1:0]            prev_q;       // previous synchronized {A,B}
  logic [1:0]            cur;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, shadow_q;
  logic                  err_q;
  logic                  inc, dec, ill;
  logic signed [DATA_WIDTH:0] sum_w, step_w;

  assign cur = {sa_q[1], sb_q[1]};

  // x4 decode of prev->cur; a double-bit change is illegal and not counted
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    ill = 1'b0;
    if (dec_en_i) begin
      case ({prev_q, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: inc = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dec = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: ill = 1'b1;
        default: ;
      endcase
    end
  end

  // saturating add of this cycle's step
  always_comb begin
    step_w = '0;
    if (inc) step_w = STEP_UP;
    else if (dec) step_w = STEP_DN;
    sum_w = $signed({acc_q[DATA_WIDTH-1], acc_q}) + step_w;
    if (sum_w > SAT_P)      sum_w = SAT_P;
    else if (sum_w < SAT_N) sum_w = SAT_N;
    acc_d = sum_w[DATA_WIDTH-1:0];
  end

  // channel state; the snapshot includes the step decoded in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      prev_q   <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sa_q   <= {sa_q[0], a_i};
      sb_q   <= {sb_q[0], b_i};
      prev_q <= cur;
      acc_q  <= snap_i ? '0 : acc_d;
      if (snap_i) shadow_q <= acc_d;
      if (ill)    err_q    <= 1'b1;
    end
  end

  assign err_o    = err_q;
  assign shadow_o = shadow_q;
endmodule

module motor_speed_decoder #(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SAMPLE_FREQ = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            enc_a,
  input  logic [3:0]            enc_b,
  output logic                  y_valid_o,
  output logic [2:0]            y_chn_o,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic [3:0]            enc_err
);
  // Window length must be at least 8 so a 4-cycle emission always ends
  // well before the next snapshot.
  localparam int SAMPLE_CYCLES = CLK_FREQ / SAMPLE_FREQ;
  localparam int WIN_W         = $clog2(SAMPLE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [WIN_W-1:0]            win_q;
  logic [1:0]                  fill_q;
  logic                        snap, dec_en;
  logic [3:0][DATA_WIDTH-1:0]  shadow;

  assign snap   = (win_q == WIN_LAST);
  // synchronizer and previous registers hold stale reset values for 3 cycles
  assign dec_en = (fill_q == 2'd3);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    motor_speed_decoder_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .a_i      (enc_a[i]),
      .b_i      (enc_b[i]),
      .dec_en_i (dec_en),
      .snap_i   (snap),
      .err_o    (enc_err[i]),
      .shadow_o (shadow[i])
    );
  end

  // window counter, post-reset fill counter and emission FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      win_q   <= snap ? '0 : win_q + WIN_W'(1);
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // emission: IDLE until snapshot, then four strobes for channels 0..3;
  // cnt_q keeps the last channel so chn/data hold while idle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_valid_o = 1'b0;
    case (state_q)
      S_IDLE: if (snap) begin
        state_d = S_EMIT;
        cnt_d   = 2'd0;
      end
      S_EMIT: begin
        y_valid_o = 1'b1;
        if (cnt_q == 2'd3) state_d = S_IDLE;
        else               cnt_d   = cnt_q + 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign y_chn_o  = {1'b0, cnt_q};
  assign y_data_o = shadow[cnt_q];
endmodule

// File: tb/tb_motor_speed_decoder.sv
// Bench for motor_speed_decoder: a 16-bit/100-cycle-window instance and an
// 8-bit/500-cycle-window instance share the encoder inputs. A transaction
// model predicts outputs every cycle; directed scenarios add literal checks.
module tb_motor_speed_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  enc_a = '0, enc_b = '0;
  logic        v16, v8;
  logic [2:0]  c16, c8;
  logic [15:0] d16;
  logic [7:0]  d8;
  logic [3:0]  e16, e8;

  int vectors = 0, miscompares = 0;
  int ecnt = 0;          // clock edges since reset was released
  bit started = 1'b0;
  int qp[4];             // quadrature position per channel: 0=00 1=10 2=11 3=01

  always #5 clk = ~clk;

  motor_speed_decoder #(.DATA_WIDTH(16), .CLK_FREQ(1000), .SAMPLE_FREQ(10)) u_dut16 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .y_valid_o(v16), .y_chn_o(c16), .y_data_o(d16), .enc_err(e16));

  motor_speed_decoder #(.DATA_WIDTH(8), .CLK_FREQ(1000), .SAMPLE_FREQ(2)) u_dut8 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .y_valid_o(v8), .y_chn_o(c8), .y_data_o(d8), .enc_err(e8));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  int acc[2][4], snap[2][4], emit[2], lchn[2], ldata[2];
  logic [3:0] err_m;
  logic [7:0] hist[$];   // last four sampled {enc_a,enc_b}

  function automatic int win_len(input int d); return d ? 500 : 100; endfunction
  function automatic int max_cnt(input int d); return d ? 127 : 32767; endfunction
  function automatic int qpos(input logic a, input logic b);
    case ({a, b})
      2'b00: return 0;
      2'b10: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction
  function automatic int clamp(input int v, input int m);
    if (v > m) return m;
    if (v < -m) return -m;
    return v;
  endfunction

  // A phase change sampled at edge j+1 is counted at edge j+3 (2-flop sync
  // plus previous register); the first 3 edges after reset count nothing.
  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      ecnt = 0;
      hist.delete();
      err_m = '0;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin acc[d][c] = 0; snap[d][c] = 0; end
        emit[d] = -1; lchn[d] = 0; ldata[d] = 0;
      end
    end else begin
      ecnt++;
      hist.push_back({enc_a, enc_b});
      if (hist.size() > 4) void'(hist.pop_front());
      for (int c = 0; c < 4; c++) begin
        int stp, dl;
        stp = 0;
        if (hist.size() == 4) begin
          dl = (qpos(hist[1][4+c], hist[1][c]) - qpos(hist[0][4+c], hist[0][c]) + 4) % 4;
          if (dl == 1) stp = 1;
          else if (dl == 3) stp = -1;
          else if (dl == 2) err_m[c] = 1'b1;
        end
        for (int d = 0; d < 2; d++) acc[d][c] = clamp(acc[d][c] + stp, max_cnt(d));
      end
      for (int d = 0; d < 2; d++) begin
        if (emit[d] >= 0) begin
          if (emit[d] == 3) begin lchn[d] = 3; ldata[d] = snap[d][3]; emit[d] = -1; end
          else emit[d]++;
        end
        if (ecnt % win_len(d) == 0) begin
          for (int c = 0; c < 4; c++) begin snap[d][c] = acc[d][c]; acc[d][c] = 0; end
          emit[d] = 0;
        end
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      int ech0, ech1, edt0, edt1;
      ech0 = (emit[0] >= 0) ? emit[0] : lchn[0];
      edt0 = (emit[0] >= 0) ? snap[0][emit[0]] : ldata[0];
      ech1 = (emit[1] >= 0) ? emit[1] : lchn[1];
      edt1 = (emit[1] >= 0) ? snap[1][emit[1]] : ldata[1];
      chk("valid16", {15'h0, v16}, {15'h0, emit[0] >= 0});
      chk("chn16",   {13'h0, c16}, 16'(ech0));
      chk("data16",  d16, 16'(edt0));
      chk("err16",   {12'h0, e16}, {12'h0, err_m});
      chk("valid8",  {15'h0, v8}, {15'h0, emit[1] >= 0});
      chk("chn8",    {13'h0, c8}, 16'(ech1));
      chk("data8",   {8'h0, d8}, {8'h0, 8'(edt1)});
      chk("err8",    {12'h0, e8}, {12'h0, err_m});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_pos(input int c, input int p);
    qp[c] = p;
    case (p)
      0: begin enc_a[c] = 1'b0; enc_b[c] = 1'b0; end
      1: begin enc_a[c] = 1'b1; enc_b[c] = 1'b0; end
      2: begin enc_a[c] = 1'b1; enc_b[c] = 1'b1; end
      default: begin enc_a[c] = 1'b0; enc_b[c] = 1'b1; end
    endcase
  endtask

  task automatic quad(input int c, input int dir, input int n, input int gap);
    repeat (n) begin
      repeat (gap) @(negedge clk);
      set_pos(c, (qp[c] + dir + 4) % 4);
    end
  endtask

  task automatic wait_win(input int per, input int off);
    int n;
    n = 0;
    while (ecnt % per != off && n <= per) begin @(negedge clk); n++; end
  endtask

  // wait for a frame, then check four consecutive strobes with literal data
  task automatic expect_frame(input int d, input int x0, input int x1, input int x2,
                              input int x3, input string nm);
    int xs[4];
    int n;
    xs = '{x0, x1, x2, x3};
    n = 0;
    while (!(d == 0 ? v16 : v8) && n < 1200) begin @(negedge clk); n++; end
    if (n >= 1200) begin
      chk({nm, "_timeout"}, 16'h0, 16'h1);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (d == 0) begin
        chk({nm, "_valid"}, {15'h0, v16}, 16'h1);
        chk({nm, "_chn"}, {13'h0, c16}, 16'(k));
        chk({nm, "_data"}, d16, 16'(xs[k]));
      end else begin
        chk({nm, "_valid"}, {15'h0, v8}, 16'h1);
        chk({nm, "_chn"}, {13'h0, c8}, 16'(k));
        chk({nm, "_data"}, {8'h0, d8}, {8'h0, 8'(xs[k])});
      end
      @(negedge clk);
    end
    chk({nm, "_end"}, {15'h0, (d == 0 ? v16 : v8)}, 16'h0);
  endtask

  initial begin
    int n;
    for (int c = 0; c < 4; c++) qp[c] = 0;
    // reset with random encoder activity
    repeat (5) begin
      @(negedge clk);
      enc_a = 4'($urandom);
      enc_b = 4'($urandom);
    end
    chk("rst_valid", {15'h0, v16}, 16'h0);
    chk("rst_data", d16, 16'h0);
    chk("rst_chn", {13'h0, c16}, 16'h0);
    chk("rst_err", {12'h0, e16 | e8}, 16'h0);
    @(negedge clk);
    enc_a = '0;
    enc_b = '0;
    @(negedge clk);
    rst = 1'b0;

    // forward: 40 edges on ch0 within the first window
    quad(0, 1, 40, 2);
    expect_frame(0, 40, 0, 0, 0, "fwd");
    chk("model_fwd", 16'(snap[0][0]), 16'd40);

    // reverse: 20 edges on ch2, last one counted in the terminal window cycle
    wait_win(100, 5);
    quad(2, -1, 19, 2);
    wait_win(100, 97);
    set_pos(2, (qp[2] + 3) % 4);
    expect_frame(0, 0, 0, -20, 0, "rev");
    chk("rev_lit", 16'(snap[0][2]), 16'hFFEC);

    // illegal 00->11 on ch1, then two legal forward edges
    wait_win(100, 5);
    set_pos(1, 2);
    repeat (4) @(negedge clk);
    chk("err_set", {12'h0, e16}, 16'h0002);
    quad(1, 1, 2, 3);
    expect_frame(0, 0, 2, 0, 0, "ill");
    expect_frame(0, 0, 0, 0, 0, "quiet");
    chk("err_held16", {12'h0, e16}, 16'h0002);
    chk("err_held8", {12'h0, e8}, 16'h0002);

    // saturation on the 8-bit instance
    wait_win(500, 5);
    quad(3, 1, 200, 2);
    expect_frame(1, 0, 0, 0, 127, "satp");
    wait_win(500, 5);
    quad(3, -1, 200, 2);
    expect_frame(1, 0, 0, 0, -127, "satn");
    chk("satn_lit", {8'h0, 8'(snap[1][3])}, 16'h0081);
    expect_frame(1, 0, 0, 0, 0, "satz");

    // reset while channel 1 is being emitted
    n = 0;
    while (!(v16 && c16 == 3'd1) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("abort_wait", 16'h0, 16'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", {15'h0, v16}, 16'h0);
    chk("abort_err", {12'h0, e16}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    quad(0, 1, 8, 2);
    expect_frame(0, 8, 0, 0, 0, "post_rst");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/motor_speed_decoder.md
MOTOR_SPEED_DECODER -- requirements
Module: motor_speed_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of signed speed sample.
REQ-002 SHALL have parameter CLK_FREQ, default 27_000_000, clk frequency in Hz.
REQ-003 SHALL have parameter SAMPLE_FREQ, default 100, measurement window rate in Hz; SAMPLE_CYCLES = CLK_FREQ/SAMPLE_FREQ, legal only if >= 8.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports enc_a  input  4  and enc_b  input  4, asynchronous quadrature phases, bit i = motor i.
REQ-007 SHALL have port y_valid_o  output  1  one-cycle strobe per emitted sample.
REQ-008 SHALL have port y_chn_o  output  3  channel index 0..3 of emitted sample.
REQ-009 SHALL have port y_data_o  output  DATA_WIDTH  signed two's-complement edge count per window.
REQ-010 SHALL have port enc_err  output  4  sticky illegal-transition flag per channel.

Function
REQ-011 SHALL pass each enc_a/enc_b bit through a 2-flop synchronizer, then a third "previous" register per channel.
REQ-012 SHALL decode x4: per channel, prev->cur {A,B} 00->10->11->01->00 = +1 (forward), reverse sequence = -1, unchanged = 0.
REQ-013 SHALL treat both bits changing in one cycle as illegal: no count, enc_err[i] set and held until rst.
REQ-014 SHALL accumulate per-channel counts in a DATA_WIDTH signed accumulator saturating at +(2^(DATA_WIDTH-1)-1) and -(2^(DATA_WIDTH-1)-1); most-negative code never produced.
REQ-015 SHALL run a window counter 0..SAMPLE_CYCLES-1, wrapping to 0.
REQ-016 SHALL, in the cycle window counter == SAMPLE_CYCLES-1, snapshot all four accumulators (including that cycle's decoded step) into shadow registers and clear accumulators to 0 on the same edge.
REQ-017 SHALL emit via FSM IDLE -> EMIT: IDLE until snapshot; EMIT for exactly 4 consecutive cycles with y_chn_o = 0,1,2,3, y_valid_o = 1, y_data_o = shadow[chn]; then IDLE.
REQ-018 SHALL assert first y_valid_o (chn 0) the cycle after the snapshot edge; fixed latency, no backpressure.
REQ-019 SHALL hold y_valid_o = 0 in IDLE; y_chn_o and y_data_o hold last emitted values.
REQ-020 SHALL keep emission and snapshot independent of decoding: edges during EMIT count into the new window.
REQ-021 SHALL per-channel channels be fully independent; simultaneous edges on all channels all counted.

Reset
REQ-022 SHALL, while rst = 1 at a clk edge, clear synchronizers, previous registers, accumulators, shadows, window counter, enc_err; FSM to IDLE; y_valid_o = 0, y_chn_o = 0, y_data_o = 0.
REQ-023 SHALL inhibit decoding (no count, no error) for the first 3 cycles after rst deasserts while synchronizer/previous registers fill.
REQ-024 SHALL abort emission if rst asserted mid-EMIT: y_valid_o = 0 next cycle, remaining channels not emitted.
REQ-025 SHALL restart window counting from 0 on the first cycle after rst deasserts.

Verification (CLK_FREQ=1000, SAMPLE_FREQ=10 -> SAMPLE_CYCLES=100 unless stated)
REQ-026 SHALL cover reset: rst high 5 cycles, random enc inputs -> all outputs 0, no y_valid_o, enc_err = 0.
REQ-027 SHALL cover forward count: ch0 10 full forward quadrature cycles (40 edges, 2 clk between edges) in one window -> 4 strobes chn 0,1,2,3 consecutive; data 40, 0, 0, 0.
REQ-028 SHALL cover reverse count: ch2 5 reverse cycles -> chn 2 data 0xFFEC (-20); edge placed in terminal window cycle counted in that window, not next.
REQ-029 SHALL cover illegal transition: ch1 {A,B} 00->11 -> enc_err = 4'b0010, ch1 count unchanged, flag held across windows until rst.
REQ-030 SHALL cover saturation: DATA_WIDTH=8, 200 forward edges ch3 in one window -> data 127; 200 reverse -> 0x81 (-127); next window restarts from 0.
REQ-031 SHALL cover reset mid-emission: rst asserted while chn 1 valid -> y_valid_o 0 next cycle, chn 2/3 never emitted, next window reports from 0.
